wb_write_arbiter: RTL and testbench

Shares the single register-file write port between the pipeline Write Back stage and the multi-cycle arithmetic unit (MDU). Pipeline writes always win. MDU results wait in a small in-order queue and retire into idle write-port cycles. The block sits between the WR stage outputs and the ID-stage register file. It also exports a pending-write mask so ID hazard logic can stall readers of queued destinations.

---
 rtl/wb_arb_pkg.sv | 15 +
 rtl/wb_arb_fifo.sv | 52 +++++
 rtl/wb_write_arbiter.sv | 77 +++++++
 tb/tb_wb_write_arbiter.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared widths, queue entry type and register one-hot helper for the write-port arbiter.
package wb_arb_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int NUM_REGS   = 1 << REG_ADDR_W;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rw;
        logic [DATA_W-1:0]     data;
    } wb_entry_t;

    function automatic logic [NUM_REGS-1:0] onehot_reg(input logic [REG_ADDR_W-1:0] rw);
        return NUM_REGS'(1) << rw;
    endfunction
endpackage

// File: rtl/wb_arb_fifo.sv
// wb_arb_fifo: in-order queue of MDU results; exposes every slot plus its valid bit for hazard masking.
module wb_arb_fifo
    import wb_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  wb_entry_t             din,
    input  logic                  pop,
    output wb_entry_t             head,
    output logic                  full,
    output logic                  empty,
    output wb_entry_t [DEPTH-1:0] entries,
    output logic      [DEPTH-1:0] valid
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    wb_entry_t [DEPTH-1:0] mem;
    logic [DEPTH-1:0] vld;
    logic [AW-1:0] wp, rp;
    logic [CW-1:0] cnt;

    // Callers only push when not full and pop when not empty, so wp != rp whenever both happen.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
            vld <= '0;
        end else begin
            if (push) begin
                mem[wp] <= din;
                vld[wp] <= 1'b1;
                wp      <= wp + AW'(1);
            end
            if (pop) begin
                vld[rp] <= 1'b0;
                rp      <= rp + AW'(1);
            end
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    end

    assign head    = mem[rp];
    assign full    = cnt == CW'(DEPTH);
    assign empty   = cnt == '0;
    assign entries = mem;
    assign valid   = vld;
endmodule

// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter: shares the register-file write port between WB (always wins) and queued MDU results.
// Optional starvation guard enabled by defining WBARB_STARVE_GUARD_EN.
module wb_write_arbiter
    import wb_arb_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wb_regwe,
    input  logic [REG_ADDR_W-1:0] wb_rw,
    input  logic [DATA_W-1:0]     wb_din,
    input  logic                  mdu_valid,
    input  logic [REG_ADDR_W-1:0] mdu_rw,
    input  logic [DATA_W-1:0]     mdu_data,
    output logic                  mdu_ready,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_rw,
    output logic [DATA_W-1:0]     rf_din,
    output logic [NUM_REGS-1:0]   pend_mask,
    output logic                  stall_req
);
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || STARVE_LIMIT < 1) begin : g_param_check
        $error("wb_write_arbiter: DEPTH must be a power of two >= 2 and STARVE_LIMIT >= 1");
    end

    wb_entry_t             head;
    wb_entry_t [DEPTH-1:0] entries;
    logic      [DEPTH-1:0] valid;
    logic full, empty, push, pop, wb_hit;

    // A $0 pipeline write is suppressed and leaves the port idle; a $0 MDU result is accepted and dropped.
    assign wb_hit    = wb_regwe && wb_rw != '0;
    assign pop       = rst_n && !wb_hit && !empty;
    assign push      = rst_n && mdu_valid && !full && mdu_rw != '0;
    assign mdu_ready = !rst_n || !full;

    wb_arb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .din     ('{rw: mdu_rw, data: mdu_data}),
        .pop     (pop),
        .head    (head),
        .full    (full),
        .empty   (empty),
        .entries (entries),
        .valid   (valid)
    );

    assign rf_we  = rst_n && (wb_hit || !empty);
    assign rf_rw  = !rst_n ? '0 : wb_hit ? wb_rw  : !empty ? head.rw   : '0;
    assign rf_din = !rst_n ? '0 : wb_hit ? wb_din : !empty ? head.data : '0;

    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < DEPTH; i++)
            pend_mask |= (rst_n && valid[i]) ? onehot_reg(entries[i].rw) : '0;
    end

`ifdef WBARB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    logic [SW-1:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || empty || pop)
            wait_cnt <= '0;
        else if (wait_cnt != SW'(STARVE_LIMIT))
            wait_cnt <= wait_cnt + SW'(1);
    end

    assign stall_req = rst_n && wait_cnt == SW'(STARVE_LIMIT);
`else
    assign stall_req = 1'b0;
`endif
endmodule

// File: tb/tb_wb_write_arbiter.sv
// tb_wb_write_arbiter: directed vectors with a per-cycle expectation queue drained by an independent monitor.
module tb_wb_write_arbiter;
    import wb_arb_pkg::*;

`ifdef WBARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wb_regwe = 1'b0;
    logic [4:0]  wb_rw = '0;
    logic [31:0] wb_din = '0;
    logic        mdu_valid = 1'b0;
    logic [4:0]  mdu_rw = '0;
    logic [31:0] mdu_data = '0;
    logic        mdu_ready, rf_we, stall_req;
    logic [4:0]  rf_rw;
    logic [31:0] rf_din, pend_mask;

    wb_write_arbiter #(.DEPTH(2), .STARVE_LIMIT(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wb_regwe  (wb_regwe),
        .wb_rw     (wb_rw),
        .wb_din    (wb_din),
        .mdu_valid (mdu_valid),
        .mdu_rw    (mdu_rw),
        .mdu_data  (mdu_data),
        .mdu_ready (mdu_ready),
        .rf_we     (rf_we),
        .rf_rw     (rf_rw),
        .rf_din    (rf_din),
        .pend_mask (pend_mask),
        .stall_req (stall_req)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  rw;
        logic [31:0] din;
        logic        rdy;
        logic [31:0] mask;
        logic        stall;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, want);
        end
    endtask

    // Monitor: every cycle with a queued expectation, compare the DUT outputs mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("rf_we", 32'(rf_we), 32'(e.we));
            check("rf_rw", 32'(rf_rw), 32'(e.rw));
            check("rf_din", rf_din, e.din);
            check("mdu_ready", 32'(mdu_ready), 32'(e.rdy));
            check("pend_mask", pend_mask, e.mask);
            check("stall_req", 32'(stall_req), 32'(e.stall));
            cyc++;
        end
    end

    task automatic step(input logic we, input logic [4:0] wrw, input logic [31:0] wd,
                        input logic mv, input logic [4:0] mrw, input logic [31:0] md,
                        input logic e_we, input logic [4:0] e_rw, input logic [31:0] e_din,
                        input logic e_rdy, input logic [31:0] e_mask, input logic e_stall);
        wb_regwe  = we;
        wb_rw     = wrw;
        wb_din    = wd;
        mdu_valid = mv;
        mdu_rw    = mrw;
        mdu_data  = md;
        exp_q.push_back('{we: e_we, rw: e_rw, din: e_din, rdy: e_rdy, mask: e_mask, stall: e_stall});
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [31:0] e_mask);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, e_mask, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        @(posedge clk);
        #1;
        // Reset held with activity on both inputs: outputs at reset values, nothing enqueued.
        step(1, 3, 32'h5, 1, 9, 32'h9, 0, 0, 0, 1, 0, 0);
        step(1, 3, 32'h5, 1, 9, 32'h9, 0, 0, 0, 1, 0, 0);
        rst_n = 1'b1;
        idle(0);
        // Idle drain.
        step(0, 0, 0, 1, 5, 32'h1234, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 5, 32'h1234, 1, 32'h20, 0);
        idle(0);
        // Pipeline priority over a queued rw=7.
        step(0, 0, 0, 1, 7, 32'h77, 0, 0, 0, 1, 0, 0);
        for (int k = 0; k < 3; k++) step(1, 3, 32'hA, 0, 0, 0, 1, 3, 32'hA, 1, 32'h80, 0);
        step(0, 0, 0, 0, 0, 0, 1, 7, 32'h77, 1, 32'h80, 0);
        idle(0);
        // Full / back-pressure, order 1,2,3.
        step(1, 4, 32'hB, 1, 1, 32'h11, 1, 4, 32'hB, 1, 32'h0, 0);
        step(1, 4, 32'hC, 1, 2, 32'h22, 1, 4, 32'hC, 1, 32'h2, 0);
        step(1, 4, 32'hD, 1, 3, 32'h33, 1, 4, 32'hD, 0, 32'h6, 0);
        step(0, 0, 0, 1, 3, 32'h33, 1, 1, 32'h11, 0, 32'h6, 0);
        step(1, 4, 32'hE, 1, 3, 32'h33, 1, 4, 32'hE, 1, 32'h4, 0);
        step(0, 0, 0, 0, 0, 0, 1, 2, 32'h22, 0, 32'hC, 0);
        step(0, 0, 0, 0, 0, 0, 1, 3, 32'h33, 1, 32'h8, 0);
        idle(0);
        // $0 handling on both sides.
        step(0, 0, 0, 1, 0, 32'hDEAD, 0, 0, 0, 1, 0, 0);
        idle(0);
        step(1, 6, 32'h66, 1, 9, 32'h99, 1, 6, 32'h66, 1, 0, 0);
        step(1, 0, 32'hBAD, 0, 0, 0, 1, 9, 32'h99, 1, 32'h200, 0);
        step(1, 0, 32'hBAD, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        // Push and pop in the same cycle.
        step(0, 0, 0, 1, 10, 32'hA0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 11, 32'hB0, 1, 10, 32'hA0, 1, 32'h400, 0);
        step(0, 0, 0, 0, 0, 0, 1, 11, 32'hB0, 1, 32'h800, 0);
        idle(0);
        // Starvation: stall_req from the 9th waiting cycle until the head pops (guard builds only).
        step(0, 0, 0, 1, 12, 32'hC0, 0, 0, 0, 1, 0, 0);
        for (int k = 1; k <= 10; k++)
            step(1, 13, 32'hD0 + k, 0, 0, 0, 1, 13, 32'hD0 + k, 1, 32'h1000, GUARD && k >= 9);
        step(0, 0, 0, 0, 0, 0, 1, 12, 32'hC0, 1, 32'h1000, GUARD);
        idle(0);
        // Reset mid-operation discards the queued entry.
        step(0, 0, 0, 1, 14, 32'hE0, 0, 0, 0, 1, 0, 0);
        rst_n = 1'b0;
        idle(0);
        rst_n = 1'b1;
        idle(0);
        idle(0);
        check("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
